fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 127 ++++++++++++
 tb/tb_fetch_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC and the IF/ID pipeline register.
// Redirects come from EX (branch, jump, JR); stall freezes everything, and halt stops fetching until reset.
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        stall,
  input  logic        flush,
  input  logic        halt,
  input  logic [1:0]  pc_src,
  input  logic        branch_taken,
  input  logic [31:0] ex_npc,
  input  logic [15:0] ex_imm16,
  input  logic [25:0] ex_jaddr,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] npc_reg, npc_next;
  logic        valid_reg, valid_next;
  logic        halted_reg, halted_next;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;
  logic        redirect;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = ex_npc + {{14{ex_imm16[15]}}, ex_imm16, 2'b00};
  assign jump_target   = {ex_npc[31:28], ex_jaddr, 2'b00};

  always_comb begin
    redirect        = 1'b0;
    redirect_target = pc_reg;
    case (pc_src)
      SRC_SEQ: begin
        redirect        = 1'b0;
        redirect_target = pc_reg;
      end
      SRC_BRANCH: begin
        redirect        = branch_taken;
        redirect_target = branch_target;
      end
      SRC_JUMP: begin
        redirect        = 1'b1;
        redirect_target = jump_target;
      end
      SRC_JR: begin
        redirect        = 1'b1;
        redirect_target = ex_rs_data;
      end
      default: begin
        redirect        = 1'b0;
        redirect_target = pc_reg;
      end
    endcase
  end

  always_comb begin
    pc_next = pc_reg;
    if (halted_reg || stall) begin
      pc_next = pc_reg;
    end else if (redirect) begin
      pc_next = redirect_target;
    end else if (ihit) begin
      pc_next = pc_plus4;
    end
  end

  // A redirect or flush squashes whatever word is arriving this cycle.
  always_comb begin
    instr_next = instr_reg;
    npc_next   = npc_reg;
    valid_next = valid_reg;
    if (!stall) begin
      if (redirect || flush || halted_reg || !ihit) begin
        instr_next = 32'd0;
        npc_next   = 32'd0;
        valid_next = 1'b0;
      end else begin
        instr_next = imemload;
        npc_next   = pc_plus4;
        valid_next = 1'b1;
      end
    end
  end

  assign halted_next = halted_reg | halt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pc_reg     <= PC_INIT;
      instr_reg  <= 32'd0;
      npc_reg    <= 32'd0;
      valid_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      instr_reg  <= instr_next;
      npc_reg    <= npc_next;
      valid_reg  <= valid_next;
      halted_reg <= halted_next;
    end
  end

  assign imemaddr   = pc_reg;
  assign imemREN    = !halted_reg;
  assign ifid_instr = instr_reg;
  assign ifid_npc   = npc_reg;
  assign ifid_valid = valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, branch/jump/JR, stall, flush,
// ihit gaps, PC wrap, halt and asynchronous reset.
module tb_fetch_stage;

  logic        CLK;
  logic        nRST;
  logic        ihit;
  logic        stall;
  logic        flush;
  logic        halt;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic [31:0] ex_npc;
  logic [15:0] ex_imm16;
  logic [25:0] ex_jaddr;
  logic [31:0] ex_rs_data;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_npc;
  logic        ifid_valid;

  int compared;
  int mismatched;

  fetch_stage #(.PC_INIT(32'h00000000)) dut (
    .CLK(CLK),
    .nRST(nRST),
    .ihit(ihit),
    .stall(stall),
    .flush(flush),
    .halt(halt),
    .pc_src(pc_src),
    .branch_taken(branch_taken),
    .ex_npc(ex_npc),
    .ex_imm16(ex_imm16),
    .ex_jaddr(ex_jaddr),
    .ex_rs_data(ex_rs_data),
    .imemload(imemload),
    .imemREN(imemREN),
    .imemaddr(imemaddr),
    .ifid_instr(ifid_instr),
    .ifid_npc(ifid_npc),
    .ifid_valid(ifid_valid)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
    $display("check %-14s observed=%h expected=%h", tag, observed, expected);
  endtask

  // Advance one rising edge and settle past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] instr, input logic [31:0] npc, input logic valid);
    check({tag, ".instr"}, ifid_instr, instr);
    check({tag, ".npc"}, ifid_npc, npc);
    check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  initial begin
    compared     = 0;
    mismatched   = 0;
    nRST         = 1'b0;
    ihit         = 1'b0;
    stall        = 1'b0;
    flush        = 1'b0;
    halt         = 1'b0;
    pc_src       = 2'b00;
    branch_taken = 1'b0;
    ex_npc       = 32'd0;
    ex_imm16     = 16'd0;
    ex_jaddr     = 26'd0;
    ex_rs_data   = 32'd0;
    imemload     = 32'd0;

    // Reset state
    step();
    check("rst.addr", imemaddr, 32'h0);
    check("rst.ren", {31'd0, imemREN}, 32'd1);
    check_ifid("rst", 32'h0, 32'h0, 1'b0);
    nRST = 1'b1;

    // Sequential fetch of A, B, C
    ihit = 1'b1;
    imemload = 32'hAAAA0001;
    check("seq.addr0", imemaddr, 32'h0);
    step();
    check("seq.addr4", imemaddr, 32'h4);
    check_ifid("seqA", 32'hAAAA0001, 32'h4, 1'b1);
    imemload = 32'hBBBB0002;
    step();
    check("seq.addr8", imemaddr, 32'h8);
    check_ifid("seqB", 32'hBBBB0002, 32'h8, 1'b1);
    imemload = 32'hCCCC0003;
    step();
    check("seq.addrC", imemaddr, 32'hC);
    check_ifid("seqC", 32'hCCCC0003, 32'hC, 1'b1);

    // JR to 0x40, then taken branch: 0x24 + (-2 << 2) = 0x1C
    pc_src = 2'b11;
    ex_rs_data = 32'h40;
    step();
    check("jr.addr40", imemaddr, 32'h40);
    check_ifid("jr", 32'h0, 32'h0, 1'b0);
    pc_src = 2'b01;
    branch_taken = 1'b1;
    ex_npc = 32'h24;
    ex_imm16 = 16'hFFFE;
    step();
    check("br.taken", imemaddr, 32'h1C);
    check_ifid("brT", 32'h0, 32'h0, 1'b0);

    // Back to 0x40, branch not taken behaves sequentially
    pc_src = 2'b11;
    step();
    check("jr.again", imemaddr, 32'h40);
    pc_src = 2'b01;
    branch_taken = 1'b0;
    imemload = 32'hDDDD0004;
    step();
    check("br.nottaken", imemaddr, 32'h44);
    check_ifid("brN", 32'hDDDD0004, 32'h44, 1'b1);

    // Jump and JR targets
    pc_src = 2'b10;
    ex_npc = 32'hA0000010;
    ex_jaddr = 26'h0000040;
    step();
    check("jump", imemaddr, 32'hA0000100);
    check_ifid("jmp", 32'h0, 32'h0, 1'b0);
    pc_src = 2'b11;
    ex_rs_data = 32'h00000200;
    step();
    check("jr200", imemaddr, 32'h200);

    // Load a real instruction, then stall two cycles with a pending jump
    pc_src = 2'b00;
    imemload = 32'hEEEE0005;
    step();
    check("pre.stall", imemaddr, 32'h204);
    check_ifid("preS", 32'hEEEE0005, 32'h204, 1'b1);
    stall = 1'b1;
    pc_src = 2'b10;
    ex_npc = 32'h10000000;
    ex_jaddr = 26'h0000100;
    imemload = 32'h12345678;
    step();
    check("stall1.pc", imemaddr, 32'h204);
    check_ifid("st1", 32'hEEEE0005, 32'h204, 1'b1);
    step();
    check("stall2.pc", imemaddr, 32'h204);
    check_ifid("st2", 32'hEEEE0005, 32'h204, 1'b1);
    stall = 1'b0;
    step();
    check("unstall.jmp", imemaddr, 32'h10000400);
    check_ifid("unst", 32'h0, 32'h0, 1'b0);

    // Flush squashes the captured word but PC still advances
    pc_src = 2'b00;
    flush = 1'b1;
    imemload = 32'hFFFF0006;
    step();
    check("flush.pc", imemaddr, 32'h10000404);
    check_ifid("fl", 32'h0, 32'h0, 1'b0);
    flush = 1'b0;

    // ihit low for 3 cycles: PC held, bubbles
    imemload = 32'h0BADF00D;
    step();
    check_ifid("ok", 32'h0BADF00D, 32'h10000408, 1'b1);
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("miss.pc", imemaddr, 32'h10000408);
      check("miss.valid", {31'd0, ifid_valid}, 32'd0);
    end

    // PC wrap at the top of the address space
    ihit = 1'b1;
    pc_src = 2'b11;
    ex_rs_data = 32'hFFFFFFFC;
    step();
    check("wrap.pre", imemaddr, 32'hFFFFFFFC);
    pc_src = 2'b00;
    imemload = 32'h77770007;
    step();
    check("wrap.pc", imemaddr, 32'h0);
    check_ifid("wrap", 32'h77770007, 32'h0, 1'b1);

    // Halt pulse during stall
    stall = 1'b1;
    halt = 1'b1;
    step();
    check("halt.ren", {31'd0, imemREN}, 32'd0);
    check("halt.pc", imemaddr, 32'h0);
    check_ifid("hlt", 32'h77770007, 32'h0, 1'b1);
    halt = 1'b0;
    stall = 1'b0;
    step();
    check("halt.pc2", imemaddr, 32'h0);
    check("halt.ren2", {31'd0, imemREN}, 32'd0);
    check_ifid("hltB", 32'h0, 32'h0, 1'b0);
    pc_src = 2'b11;
    ex_rs_data = 32'h300;
    step();
    check("halt.redir", imemaddr, 32'h0);
    pc_src = 2'b00;

    // Mid-fetch asynchronous reset clears halted immediately
    #2;
    nRST = 1'b0;
    #1;
    check("arst.ren", {31'd0, imemREN}, 32'd1);
    check("arst.addr", imemaddr, 32'h0);
    step();
    nRST = 1'b1;
    imemload = 32'h99990009;
    step();
    check("post.addr", imemaddr, 32'h4);
    check_ifid("post", 32'h99990009, 32'h4, 1'b1);

    // Async reset mid-stall from a non-init PC
    stall = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check("arst2.addr", imemaddr, 32'h0);
    check_ifid("arst2", 32'h0, 32'h0, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
